egress_frame_arbiter: RTL and testbench

- Per-egress-port scheduler that shares one egress AXIS port among NUM_REQ ingress filter outputs.
- Each requester carries tdest. Only requesters with tdest == EGRESS_ID and their enable bit set compete.
- Grants are frame-atomic and round-robin. Optional stall watchdog releases a hung grant.
- One instance per egress port sits between the ingress_filter array and the egress ports.

---
 rtl/egress_frame_arbiter.sv | 139 +++++++++++++
 tb/tb_egress_frame_arbiter.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/egress_frame_arbiter.sv
// rtl/egress_frame_arbiter.sv - frame-atomic round-robin arbiter sharing one egress stream among NUM_REQ requesters
// Define EGRESS_ARB_WATCHDOG_EN to add the stall watchdog that releases a grant idle for TIMEOUT_CYCLES.
module egress_frame_arbiter #(
    parameter int         NUM_REQ        = 4,
    parameter logic [1:0] EGRESS_ID      = 2'd0,
    parameter int         TIMEOUT_CYCLES = 256
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_REQ-1:0]     req_en,
    input  logic [16*NUM_REQ-1:0]  req_tdata,
    input  logic [2*NUM_REQ-1:0]   req_tdest,
    input  logic [NUM_REQ-1:0]     req_tvalid,
    input  logic [NUM_REQ-1:0]     req_tlast,
    output logic [NUM_REQ-1:0]     req_tready,
    output logic [15:0]            egr_tdata,
    output logic                   egr_tvalid,
    output logic                   egr_tlast,
    input  logic                   egr_tready,
    output logic [1:0]             grant_id,
    output logic                   busy,
    output logic [31:0]            frames_out,
    output logic                   timeout
);
    typedef enum logic {IDLE, BUSY} state_t;

    state_t               state, state_nxt;
    logic [1:0]           ptr;
    logic [1:0]           ptr_after;
    logic [NUM_REQ-1:0]   eligible;
    logic                 any_eligible;
    logic [1:0]           pick;
    logic [2:0]           scan_idx;
    logic                 accept;
    logic                 frame_done;
    logic                 wd_fire;

    always_comb begin
        eligible = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            eligible[i] = req_en[i] & req_tvalid[i] & (req_tdest[2*i +: 2] == EGRESS_ID);
        end
    end

    // Scan downward so the closest index at or after ptr is the last one written.
    always_comb begin
        pick         = 2'd0;
        any_eligible = 1'b0;
        scan_idx     = 3'd0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            scan_idx = {1'b0, ptr} + 3'(k);
            if (scan_idx >= 3'(NUM_REQ)) begin
                scan_idx = scan_idx - 3'(NUM_REQ);
            end
            if (eligible[scan_idx[1:0]]) begin
                pick         = scan_idx[1:0];
                any_eligible = 1'b1;
            end
        end
    end

    assign busy       = (state == BUSY);
    assign accept     = busy & req_tvalid[grant_id] & egr_tready;
    assign frame_done = accept & req_tlast[grant_id];
    assign ptr_after  = (grant_id == 2'(NUM_REQ - 1)) ? 2'd0 : grant_id + 2'd1;

    always_comb begin
        egr_tdata  = 16'd0;
        egr_tvalid = 1'b0;
        egr_tlast  = 1'b0;
        req_tready = '0;
        state_nxt  = state;
        case (state)
            IDLE: begin
                if (any_eligible) begin
                    state_nxt = BUSY;
                end
            end
            BUSY: begin
                egr_tdata            = req_tdata[16*grant_id +: 16];
                egr_tvalid           = req_tvalid[grant_id];
                egr_tlast            = req_tlast[grant_id];
                req_tready[grant_id] = egr_tready;
                if (frame_done || wd_fire) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= IDLE;
            grant_id   <= 2'd0;
            ptr        <= 2'd0;
            frames_out <= 32'd0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && any_eligible) begin
                grant_id <= pick;
            end
            if (frame_done) begin
                frames_out <= frames_out + 32'd1;
            end
            if (frame_done || wd_fire) begin
                ptr <= ptr_after;
            end
        end
    end

`ifdef EGRESS_ARB_WATCHDOG_EN
    logic [31:0] wd_cnt;
    logic        stalled;

    // Only a ready egress with a silent granted requester counts as a stall.
    assign stalled = busy & egr_tready & ~req_tvalid[grant_id];
    assign wd_fire = stalled & (wd_cnt == 32'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (!reset) begin
            wd_cnt  <= 32'd0;
            timeout <= 1'b0;
        end else begin
            timeout <= wd_fire;
            if (!busy || accept || wd_fire) begin
                wd_cnt <= 32'd0;
            end else if (stalled) begin
                wd_cnt <= wd_cnt + 32'd1;
            end
        end
    end
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = (TIMEOUT_CYCLES == 0);
    assign wd_fire = 1'b0;
    assign timeout = 1'b0;
`endif
endmodule

// File: tb/tb_egress_frame_arbiter.sv
// tb/tb_egress_frame_arbiter.sv - directed vector bench for egress_frame_arbiter
module tb_egress_frame_arbiter;
    logic        clk;
    logic        reset;
    logic [3:0]  req_en;
    logic [63:0] req_tdata;
    logic [7:0]  req_tdest;
    logic [3:0]  req_tvalid;
    logic [3:0]  req_tlast;
    logic [3:0]  req_tready;
    logic [15:0] egr_tdata;
    logic        egr_tvalid;
    logic        egr_tlast;
    logic        egr_tready;
    logic [1:0]  grant_id;
    logic        busy;
    logic [31:0] frames_out;
    logic        timeout;

    int n_vec = 0;
    int n_miss = 0;

    egress_frame_arbiter #(.NUM_REQ(4), .EGRESS_ID(2'd0), .TIMEOUT_CYCLES(4)) dut (
        .clk(clk), .reset(reset), .req_en(req_en), .req_tdata(req_tdata),
        .req_tdest(req_tdest), .req_tvalid(req_tvalid), .req_tlast(req_tlast),
        .req_tready(req_tready), .egr_tdata(egr_tdata), .egr_tvalid(egr_tvalid),
        .egr_tlast(egr_tlast), .egr_tready(egr_tready), .grant_id(grant_id),
        .busy(busy), .frames_out(frames_out), .timeout(timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic [3:0]  en, vld, lst;
        logic [7:0]  dst;
        logic [63:0] dat;
        logic        rdy;
        logic        busy;
        logic [1:0]  gid;
        logic        ev, el;
        logic [15:0] ed;
        logic [3:0]  trd;
        logic [31:0] fr;
        logic        to;
    } vec_t;

    vec_t vq[$];

    function automatic logic [63:0] pk(input logic [15:0] r0, r1, r2, r3);
        return {r3, r2, r1, r0};
    endfunction

    function automatic vec_t mk(input logic rst, input logic [3:0] en, vld, lst,
                                input logic [7:0] dst, input logic [63:0] dat, input logic rdy,
                                input logic bz, input logic [1:0] gid, input logic ev, el,
                                input logic [15:0] ed, input logic [3:0] trd,
                                input logic [31:0] fr, input logic to);
        vec_t v;
        v.rst = rst; v.en = en; v.vld = vld; v.lst = lst; v.dst = dst; v.dat = dat; v.rdy = rdy;
        v.busy = bz; v.gid = gid; v.ev = ev; v.el = el; v.ed = ed; v.trd = trd; v.fr = fr; v.to = to;
        return v;
    endfunction

    function automatic vec_t vi(input logic rst, input logic [3:0] en, vld, lst,
                                input logic [7:0] dst, input logic [63:0] dat, input logic rdy,
                                input logic [1:0] gid, input logic [31:0] fr);
        return mk(rst, en, vld, lst, dst, dat, rdy, 1'b0, gid, 1'b0, 1'b0, 16'h0, 4'h0, fr, 1'b0);
    endfunction

    function automatic vec_t vb(input logic rst, input logic [3:0] en, vld, lst,
                                input logic [7:0] dst, input logic [63:0] dat, input logic rdy,
                                input logic [1:0] gid, input logic ev, el, input logic [15:0] ed,
                                input logic [3:0] trd, input logic [31:0] fr);
        return mk(rst, en, vld, lst, dst, dat, rdy, 1'b1, gid, ev, el, ed, trd, fr, 1'b0);
    endfunction

    task automatic cmp(input string tag, input string f, input logic [31:0] a, input logic [31:0] e);
        if (a !== e) begin
            n_miss++;
            $display("FAIL %s %s: got %0h, expected %0h", tag, f, a, e);
        end
    endtask

    task automatic apply(input vec_t v, input string tag);
        @(negedge clk);
        reset = v.rst; req_en = v.en; req_tvalid = v.vld; req_tlast = v.lst;
        req_tdest = v.dst; req_tdata = v.dat; egr_tready = v.rdy;
        #1;
        n_vec++;
        cmp(tag, "busy", 32'(busy), 32'(v.busy));
        cmp(tag, "grant_id", 32'(grant_id), 32'(v.gid));
        cmp(tag, "egr_tvalid", 32'(egr_tvalid), 32'(v.ev));
        cmp(tag, "egr_tlast", 32'(egr_tlast), 32'(v.el));
        cmp(tag, "egr_tdata", 32'(egr_tdata), 32'(v.ed));
        cmp(tag, "req_tready", 32'(req_tready), 32'(v.trd));
        cmp(tag, "frames_out", frames_out, v.fr);
        cmp(tag, "timeout", 32'(timeout), 32'(v.to));
    endtask

    initial begin
        logic [63:0] d3;
        logic [1:0]  gbase;
        logic [31:0] fbase;
        reset = 1'b0; req_en = '0; req_tvalid = '0; req_tlast = '0;
        req_tdest = '0; req_tdata = '0; egr_tready = 1'b1;
        d3 = pk(16'h3000, 16'h3001, 16'h3002, 16'h3003);

        // two competing 3-beat frames, then an off-port requester, then full rotation
        vq.push_back(vi(0, 4'h0, 4'h0, 4'h0, 8'h00, 64'h0, 1, 2'd0, 0));
        vq.push_back(vi(1, 4'hF, 4'h5, 4'h0, 8'h00, pk(16'h1001, 0, 16'h2001, 0), 1, 2'd0, 0));
        vq.push_back(vb(1, 4'hF, 4'h5, 4'h0, 8'h00, pk(16'h1001, 0, 16'h2001, 0), 1, 2'd0, 1, 0, 16'h1001, 4'h1, 0));
        vq.push_back(vb(1, 4'hF, 4'h5, 4'h0, 8'h00, pk(16'h1002, 0, 16'h2001, 0), 1, 2'd0, 1, 0, 16'h1002, 4'h1, 0));
        vq.push_back(vb(1, 4'hF, 4'h5, 4'h1, 8'h00, pk(16'h1003, 0, 16'h2001, 0), 1, 2'd0, 1, 1, 16'h1003, 4'h1, 0));
        vq.push_back(vi(1, 4'hF, 4'h4, 4'h0, 8'h00, pk(0, 0, 16'h2001, 0), 1, 2'd0, 1));
        vq.push_back(vb(1, 4'hF, 4'h4, 4'h0, 8'h00, pk(0, 0, 16'h2001, 0), 1, 2'd2, 1, 0, 16'h2001, 4'h4, 1));
        vq.push_back(vb(1, 4'hF, 4'h4, 4'h0, 8'h00, pk(0, 0, 16'h2002, 0), 1, 2'd2, 1, 0, 16'h2002, 4'h4, 1));
        vq.push_back(vb(1, 4'hF, 4'h4, 4'h4, 8'h00, pk(0, 0, 16'h2003, 0), 1, 2'd2, 1, 1, 16'h2003, 4'h4, 1));
        vq.push_back(vi(1, 4'hF, 4'h0, 4'h0, 8'h00, 64'h0, 1, 2'd2, 2));
        for (int i = 0; i < 3; i++)
            vq.push_back(vi(1, 4'hF, 4'h2, 4'h0, 8'h04, pk(0, 16'h1234, 0, 0), 1, 2'd2, 2));
        vq.push_back(vi(0, 4'hF, 4'hF, 4'hF, 8'h00, d3, 1, 2'd2, 2));
        for (int k = 0; k < 8; k++) begin
            vq.push_back(vi(1, 4'hF, 4'hF, 4'hF, 8'h00, d3, 1, (k == 0) ? 2'd0 : 2'((k - 1) % 4), 32'(k)));
            vq.push_back(vb(1, 4'hF, 4'hF, 4'hF, 8'h00, d3, 1, 2'(k % 4), 1, 1,
                            16'(16'h3000 + (k % 4)), 4'(1 << (k % 4)), 32'(k)));
        end
        vq.push_back(vi(1, 4'hF, 4'h0, 4'h0, 8'h00, d3, 1, 2'd3, 8));

        foreach (vq[i]) apply(vq[i], $sformatf("tbl[%0d]", i));

        // backpressure plus enable drop mid-frame on requester 1
        apply(vi(1, 4'hF, 4'h2, 4'h0, 8'h00, pk(0, 16'h4001, 0, 0), 1, 2'd3, 8), "bp0");
        apply(vb(1, 4'hF, 4'h2, 4'h0, 8'h00, pk(0, 16'h4001, 0, 0), 1, 2'd1, 1, 0, 16'h4001, 4'h2, 8), "bp1");
        for (int i = 0; i < 10; i++)
            apply(vb(1, 4'hD, 4'h2, 4'h0, 8'h00, pk(0, 16'h4002, 0, 0), 0, 2'd1, 1, 0, 16'h4002, 4'h0, 8),
                  $sformatf("bp_hold[%0d]", i));
        apply(vb(1, 4'hD, 4'h2, 4'h0, 8'h00, pk(0, 16'h4002, 0, 0), 1, 2'd1, 1, 0, 16'h4002, 4'h2, 8), "bp2");
        apply(vb(1, 4'hD, 4'h2, 4'h2, 8'h00, pk(0, 16'h4003, 0, 0), 1, 2'd1, 1, 1, 16'h4003, 4'h2, 8), "bp3");
        apply(vi(1, 4'hD, 4'h2, 4'h0, 8'h00, pk(0, 16'h4009, 0, 0), 1, 2'd1, 9), "excl0");
        apply(vi(1, 4'hD, 4'h2, 4'h0, 8'h00, pk(0, 16'h4009, 0, 0), 1, 2'd1, 9), "excl1");
        apply(vi(1, 4'hD, 4'hA, 4'h8, 8'h00, pk(0, 16'h4009, 0, 16'h4301), 1, 2'd1, 9), "excl2");
        apply(vb(1, 4'hD, 4'hA, 4'h8, 8'h00, pk(0, 16'h4009, 0, 16'h4301), 1, 2'd3, 1, 1, 16'h4301, 4'h8, 9), "excl3");
        apply(vi(1, 4'hF, 4'h0, 4'h0, 8'h00, 64'h0, 1, 2'd3, 10), "excl4");

`ifdef EGRESS_ARB_WATCHDOG_EN
        apply(vi(1, 4'hF, 4'h1, 4'h0, 8'h00, pk(16'h5001, 0, 0, 0), 1, 2'd3, 10), "wd0");
        apply(vb(1, 4'hF, 4'h1, 4'h0, 8'h00, pk(16'h5001, 0, 0, 0), 1, 2'd0, 1, 0, 16'h5001, 4'h1, 10), "wd1");
        for (int i = 0; i < 4; i++)
            apply(vb(1, 4'hF, 4'h4, 4'h4, 8'h00, pk(16'h5001, 0, 16'h5201, 0), 1, 2'd0, 0, 0, 16'h5001, 4'h1, 10),
                  $sformatf("wd_stall[%0d]", i));
        apply(mk(1, 4'hF, 4'h4, 4'h4, 8'h00, pk(16'h5001, 0, 16'h5201, 0), 1, 0, 2'd0, 0, 0, 16'h0, 4'h0, 10, 1), "wd_fire");
        apply(vb(1, 4'hF, 4'h4, 4'h4, 8'h00, pk(16'h5001, 0, 16'h5201, 0), 1, 2'd2, 1, 1, 16'h5201, 4'h4, 10), "wd_next");
        apply(vi(1, 4'hF, 4'h0, 4'h0, 8'h00, 64'h0, 1, 2'd2, 11), "wd_end");
        gbase = 2'd2; fbase = 11;
`else
        gbase = 2'd3; fbase = 10;
`endif

        // reset during beat 2 abandons the frame
        apply(vi(1, 4'hF, 4'h1, 4'h0, 8'h00, pk(16'h6001, 0, 0, 0), 1, gbase, fbase), "rst0");
        apply(vb(1, 4'hF, 4'h1, 4'h0, 8'h00, pk(16'h6001, 0, 0, 0), 1, 2'd0, 1, 0, 16'h6001, 4'h1, fbase), "rst1");
        apply(vb(0, 4'hF, 4'h1, 4'h0, 8'h00, pk(16'h6002, 0, 0, 0), 1, 2'd0, 1, 0, 16'h6002, 4'h1, fbase), "rst2");
        apply(vi(1, 4'hF, 4'h0, 4'h0, 8'h00, 64'h0, 1, 2'd0, 0), "rst3");
        apply(vi(1, 4'hF, 4'h0, 4'h0, 8'h00, 64'h0, 1, 2'd0, 0), "rst4");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
